// File: rtl/tx_byte_queue.sv
// Byte FIFO feeding a uart_tx: one launch pulse per byte, waits for tx_done, then enforces GAP_CYCLES idle clocks.
// Pop at the edge after a write into an empty idle queue, pulse one edge later; in_ready drops when DEPTH bytes wait.
module tx_byte_queue #(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  input  logic                     tx_done,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drained,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, GAP} state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [GW-1:0]   gap_cnt;
  logic            full, empty, push, pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready && !flush;
  assign drained  = empty && (state == IDLE);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: state_nxt = BUSY;
      BUSY: begin
        if (tx_done) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt <= GW'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      pop       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      gap_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      overflow  <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      gap_cnt   <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        out_data <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
      end
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
      if (in_valid && full) overflow <= 1'b1;
      // Registered image of LAUNCH: the pulse trails the pop by one clock.
      out_valid <= (state == LAUNCH);
      if (state == BUSY && tx_done)    gap_cnt <= GW'(GAP_CYCLES);
      else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
    end
  end

endmodule

// File: tb/tb_tx_byte_queue.sv
// Directed bench for tx_byte_queue: vector table for single-byte timing plus hand sequences for multi-cycle cases.
module tb_tx_byte_queue;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, tx_done;
  logic [7:0] in_data;
  logic       in_ready, out_valid, drained, overflow;
  logic [7:0] out_data;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;

  tx_byte_queue #(.DEPTH(16), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .tx_done(tx_done),
    .count(count), .drained(drained), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         pre;
    logic       fl, vld;
    logic [7:0] dat;
    logic       done;
    logic       e_rdy, e_vld;
    logic [7:0] e_dat;
    logic [4:0] e_cnt;
    logic       e_drn, e_ovf;
  } vec_t;

  vec_t       vec [16];
  logic [7:0] exp_q [$];
  logic [7:0] d;
  logic       ok;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_tick();
    flush = 1'b0; in_valid = 1'b0; tx_done = 1'b0;
    tick();
  endtask

  task automatic write_byte(input logic [7:0] b);
    in_valid = 1'b1; in_data = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_launch(output logic [7:0] b, output logic seen);
    seen = 1'b0;
    b    = 8'h00;
    for (int n = 0; n < 60 && !seen; n++) begin
      idle_tick();
      if (out_valid) begin
        b    = out_data;
        seen = 1'b1;
      end
    end
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  // FSM is busy with an already-checked byte; releases it and checks each following launch.
  task automatic drain_check(input string tag);
    logic extra;
    for (int i = 0; i < exp_q.size(); i++) begin
      pulse_done();
      wait_launch(d, ok);
      chk({tag, "_seen"}, i, 32'(ok), 32'd1);
      chk(tag, i, 32'(d), 32'(exp_q[i]));
    end
    pulse_done();
    extra = 1'b0;
    for (int n = 0; n < 10; n++) begin
      idle_tick();
      if (out_valid) extra = 1'b1;
    end
    chk({tag, "_extra_launch"}, 0, 32'(extra), 32'd0);
    chk({tag, "_drained"}, 0, 32'(drained), 32'd1);
  endtask

  function automatic logic [7:0] sval(input int i);
    return 8'((i * 7 + 3) & 255);
  endfunction

  initial begin
    //          pre fl vld dat    done rdy vld e_dat  cnt drn ovf
    vec[0]  = '{0, 0, 1, 8'h4E, 0, 1, 0, 8'h00, 5'd1, 0, 0};
    vec[1]  = '{0, 0, 0, 8'h00, 0, 1, 0, 8'h4E, 5'd0, 0, 0};
    vec[2]  = '{0, 0, 0, 8'h00, 0, 1, 1, 8'h4E, 5'd0, 0, 0};
    vec[3]  = '{0, 0, 0, 8'h00, 0, 1, 0, 8'h4E, 5'd0, 0, 0};
    vec[4]  = '{7, 0, 0, 8'h00, 1, 1, 0, 8'h4E, 5'd0, 0, 0};
    vec[5]  = '{0, 0, 0, 8'h00, 0, 1, 0, 8'h4E, 5'd0, 0, 0};
    vec[6]  = '{0, 0, 0, 8'h00, 0, 1, 0, 8'h4E, 5'd0, 1, 0};
    vec[7]  = '{0, 0, 0, 8'h00, 1, 1, 0, 8'h4E, 5'd0, 1, 0};
    vec[8]  = '{0, 0, 0, 8'h00, 0, 1, 0, 8'h4E, 5'd0, 1, 0};
    vec[9]  = '{0, 0, 1, 8'h31, 0, 1, 0, 8'h4E, 5'd1, 0, 0};
    vec[10] = '{0, 0, 0, 8'h00, 1, 1, 0, 8'h31, 5'd0, 0, 0};
    vec[11] = '{0, 0, 0, 8'h00, 1, 1, 1, 8'h31, 5'd0, 0, 0};
    vec[12] = '{3, 0, 0, 8'h00, 0, 1, 0, 8'h31, 5'd0, 0, 0};
    vec[13] = '{0, 0, 0, 8'h00, 1, 1, 0, 8'h31, 5'd0, 0, 0};
    vec[14] = '{0, 0, 0, 8'h00, 0, 1, 0, 8'h31, 5'd0, 0, 0};
    vec[15] = '{0, 0, 0, 8'h00, 0, 1, 0, 8'h31, 5'd0, 1, 0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; tx_done = 1'b0;
    #3;
    chk("rst_in_ready", 0, 32'(in_ready), 32'd1);
    chk("rst_drained", 0, 32'(drained), 32'd1);
    chk("rst_out_valid", 0, 32'(out_valid), 32'd0);
    chk("rst_count", 0, 32'(count), 32'd0);
    chk("rst_overflow", 0, 32'(overflow), 32'd0);
    chk("rst_out_data", 0, 32'(out_data), 32'd0);
    #9 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      repeat (vec[i].pre) idle_tick();
      flush = vec[i].fl; in_valid = vec[i].vld; in_data = vec[i].dat; tx_done = vec[i].done;
      tick();
      flush = 1'b0; in_valid = 1'b0; tx_done = 1'b0;
      chk("vec_in_ready", i, 32'(in_ready), 32'(vec[i].e_rdy));
      chk("vec_out_valid", i, 32'(out_valid), 32'(vec[i].e_vld));
      chk("vec_out_data", i, 32'(out_data), 32'(vec[i].e_dat));
      chk("vec_count", i, 32'(count), 32'(vec[i].e_cnt));
      chk("vec_drained", i, 32'(drained), 32'(vec[i].e_drn));
      chk("vec_overflow", i, 32'(overflow), 32'(vec[i].e_ovf));
    end

    // 40-byte stream through the wrap, uart answering 3 clocks after each launch.
    begin
      int wr_i = 0, got = 0, cyc = 0, lat = -1;
      while (got < 40 && cyc < 3000) begin
        in_valid = (wr_i < 40) && in_ready;
        in_data  = sval(wr_i);
        tx_done  = (lat == 0);
        tick();
        cyc++;
        if (in_valid) wr_i++;
        if (tx_done) lat = -1;
        else if (lat > 0) lat--;
        if (out_valid) begin
          chk("stream_byte", got, 32'(out_data), 32'(sval(got)));
          got++;
          lat = 3;
        end
      end
      in_valid = 1'b0; tx_done = 1'b0;
      chk("stream_total", 0, 32'(got), 32'd40);
      chk("stream_overflow", 0, 32'(overflow), 32'd0);
      exp_q.delete();
      drain_check("stream_tail");
    end

    // Push and pop on the same edge with five bytes waiting.
    write_byte(8'h80);
    wait_launch(d, ok);
    chk("pp_first", 0, 32'(d), 32'h80);
    for (int i = 1; i <= 5; i++) write_byte(8'(8'h80 + i));
    chk("pp_count_pre", 0, 32'(count), 32'd5);
    pulse_done();
    idle_tick();
    idle_tick();
    chk("pp_count_idle", 0, 32'(count), 32'd5);
    write_byte(8'h86);
    chk("pp_count_same_edge", 0, 32'(count), 32'd5);
    idle_tick();
    chk("pp_launch_vld", 0, 32'(out_valid), 32'd1);
    chk("pp_launch_dat", 0, 32'(out_data), 32'h81);
    exp_q = '{8'h82, 8'h83, 8'h84, 8'h85, 8'h86};
    drain_check("pp_order");

    // Fill to DEPTH behind a stalled uart, then offer one more.
    write_byte(8'hF0);
    wait_launch(d, ok);
    chk("burst_head", 0, 32'(d), 32'hF0);
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    chk("burst_count", 0, 32'(count), 32'd16);
    chk("burst_in_ready", 0, 32'(in_ready), 32'd0);
    chk("burst_ovf_pre", 0, 32'(overflow), 32'd0);
    write_byte(8'hAA);
    chk("burst_ovf", 0, 32'(overflow), 32'd1);
    chk("burst_count_held", 0, 32'(count), 32'd16);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    drain_check("burst_order");
    chk("burst_ovf_sticky", 0, 32'(overflow), 32'd1);

    // Flush while busy with six queued and a concurrent write.
    write_byte(8'h90);
    wait_launch(d, ok);
    chk("flush_head", 0, 32'(d), 32'h90);
    for (int i = 1; i <= 6; i++) write_byte(8'(8'h90 + i));
    chk("flush_count_pre", 0, 32'(count), 32'd6);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", 0, 32'(count), 32'd0);
    chk("flush_overflow", 0, 32'(overflow), 32'd0);
    chk("flush_drained", 0, 32'(drained), 32'd1);
    pulse_done();
    begin
      logic extra = 1'b0;
      for (int n = 0; n < 10; n++) begin
        idle_tick();
        if (out_valid) extra = 1'b1;
      end
      chk("flush_no_launch", 0, 32'(extra), 32'd0);
      chk("flush_drained_after", 0, 32'(drained), 32'd1);
    end

    // Asynchronous reset while the launch pulse is high.
    write_byte(8'h5A);
    idle_tick();
    idle_tick();
    chk("arst_pre_vld", 0, 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld_drop", 0, 32'(out_valid), 32'd0);
    chk("arst_out_data", 0, 32'(out_data), 32'd0);
    chk("arst_drained", 0, 32'(drained), 32'd1);
    rst_n = 1'b1;
    pulse_done();
    begin
      logic extra = 1'b0;
      for (int n = 0; n < 6; n++) begin
        idle_tick();
        if (out_valid) extra = 1'b1;
      end
      chk("arst_no_launch", 0, 32'(extra), 32'd0);
    end
    chk("arst_hold_data", 0, 32'(out_data), 32'd0);
    chk("arst_hold_count", 0, 32'(count), 32'd0);
    chk("arst_hold_ready", 0, 32'(in_ready), 32'd1);
    chk("arst_hold_ovf", 0, 32'(overflow), 32'd0);
    write_byte(8'h5B);
    wait_launch(d, ok);
    chk("arst_relaunch_seen", 0, 32'(ok), 32'd1);
    chk("arst_relaunch", 0, 32'(d), 32'h5B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
